// File: rtl/pwb_pkg.sv
// Shared types and helpers for the 3x3 pixel window buffer.
// Window tap k sits at win_idx(r, c) = 3*r + c, with r0 the oldest row and c0 the leftmost column.
package pwb_pkg;

  localparam int PIX_W_DEFAULT = 9;
  localparam int WIN_TAPS      = 9;

  typedef logic [PIX_W_DEFAULT-1:0] pix_t;
  typedef pix_t [WIN_TAPS-1:0]      win_t;

  function automatic int win_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/pixel_window_buffer_line_buffer.sv
// One image row of pixel storage: combinational read and synchronous write at the same column address.
// The contents are never reset, because every entry is rewritten before it can reach a window.
module line_buffer
  import pwb_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int AW    = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem_q [IMG_W];

  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/pixel_window_buffer.sv
// Raster pixel stream in, fully populated 3x3 neighbourhoods out over valid/ready, with no border padding.
// Optional sticky frame-sync error flag: define PWB_SOF_ERR_EN.
module pixel_window_buffer
  import pwb_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PIX_W-1:0]   in_pixel,
  input  logic               in_sof,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [9*PIX_W-1:0] out_window,
  output logic               out_last
`ifdef PWB_SOF_ERR_EN
  ,
  output logic               sof_err
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]      col_q, col_d, eff_col;
  logic [RW-1:0]      row_q, row_d, eff_row;
  logic [PIX_W-1:0]   win_q [WIN_TAPS];
  logic [PIX_W-1:0]   win_d [WIN_TAPS];
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [9*PIX_W-1:0] out_window_q, out_window_d;
  logic [PIX_W-1:0]   lb0_rd, lb1_rd;
  logic               accept, load;

  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // A start-of-frame pixel is placed at (0,0) whatever the counters say.
  assign eff_col = in_sof ? '0 : col_q;
  assign eff_row = in_sof ? '0 : row_q;
  assign load    = accept && (eff_row >= RW'(2)) && (eff_col >= CW'(2));

  line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (eff_col),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (eff_col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_window_d = out_window_q;
    for (int k = 0; k < WIN_TAPS; k++) begin
      win_d[k] = win_q[k];
    end

    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[win_idx(r, 0)] = win_q[win_idx(r, 1)];
        win_d[win_idx(r, 1)] = win_q[win_idx(r, 2)];
      end
      win_d[win_idx(0, 2)] = lb1_rd;
      win_d[win_idx(1, 2)] = lb0_rd;
      win_d[win_idx(2, 2)] = in_pixel;

      if (eff_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (eff_row == RW'(IMG_H - 1)) ? '0 : eff_row + RW'(1);
      end else begin
        col_d = eff_col + CW'(1);
        row_d = eff_row;
      end
    end

    // Loading wins over popping, so a simultaneous pop and load keeps out_valid high.
    if (load) begin
      out_valid_d = 1'b1;
      out_last_d  = (eff_row == RW'(IMG_H - 1)) && (eff_col == CW'(IMG_W - 1));
      for (int k = 0; k < WIN_TAPS; k++) begin
        out_window_d[k*PIX_W +: PIX_W] = win_d[k];
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_window_q <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_window_q <= out_window_d;
    end
  end

  for (genvar gi = 0; gi < WIN_TAPS; gi++) begin : g_tap
    always_ff @(posedge clk) begin
      if (rst) begin
        win_q[gi] <= '0;
      end else begin
        win_q[gi] <= win_d[gi];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign out_window = out_window_q;

`ifdef PWB_SOF_ERR_EN
  logic sof_err_q, sof_err_d;
  logic seen_q, seen_d;

  // seen_q marks that a frame has already started, so a later (0,0) without in_sof is a sync error.
  always_comb begin
    sof_err_d = sof_err_q;
    seen_d    = seen_q;
    if (accept) begin
      seen_d = 1'b1;
      if ((in_sof && ((col_q != '0) || (row_q != '0))) ||
          (!in_sof && (col_q == '0) && (row_q == '0) && seen_q)) begin
        sof_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sof_err_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      sof_err_q <= sof_err_d;
      seen_q    <= seen_d;
    end
  end

  assign sof_err = sof_err_q;
`endif

endmodule

// File: tb/tb_pixel_window_buffer.sv
// Bench for pixel_window_buffer with a 4x4 image: a frame-image reference model predicts every 3x3 window.
module tb_pixel_window_buffer;

  localparam int PW   = 9;
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_pixel;
  logic            in_sof;
  logic            out_valid;
  logic            out_ready;
  logic [9*PW-1:0] out_window;
  logic            out_last;
`ifdef PWB_SOF_ERR_EN
  logic            sof_err;
`endif

  typedef struct packed {
    logic [9*PW-1:0] w;
    logic            last;
  } rec_t;

  int      vectors     = 0;
  int      miscompares = 0;
  rec_t    got_q[$];
  rec_t    exp_q[$];
  logic [PW-1:0] img [NPIX];
  int      pos;
  bit      done;

  always #5 clk = ~clk;

  pixel_window_buffer #(.PIX_W(PW), .IMG_W(W), .IMG_H(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_last   (out_last)
`ifdef PWB_SOF_ERR_EN
    ,
    .sof_err    (sof_err)
`endif
  );

  // Record every window the convolver side actually pops.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      rec_t r;
      r.w    = out_window;
      r.last = out_last;
      got_q.push_back(r);
    end
  end

  // Window whose top-left pixel value is base, in a frame where pixel value equals raster index plus offset.
  function automatic logic [9*PW-1:0] mkwin(input int base);
    logic [9*PW-1:0] w;
    for (int k = 0; k < 9; k++) begin
      w[k*PW +: PW] = PW'(base + (k / 3) * W + (k % 3));
    end
    return w;
  endfunction

  task automatic model_reset();
    pos = 0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Reference: place the pixel in a frame image; any pixel at row>=2,col>=2 completes the window ending there.
  task automatic model_accept(input logic [PW-1:0] p, input logic s);
    int r, c;
    rec_t e;
    if (s) pos = 0;
    img[pos] = p;
    r = pos / W;
    c = pos % W;
    if (r >= 2 && c >= 2) begin
      for (int k = 0; k < 9; k++) begin
        e.w[k*PW +: PW] = img[(r - 2 + k / 3) * W + (c - 2 + k % 3)];
      end
      e.last = (pos == NPIX - 1);
      exp_q.push_back(e);
    end
    pos = (pos + 1) % NPIX;
  endtask

  task automatic push(input logic [PW-1:0] p, input logic s);
    int t = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_sof   = s;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: in_ready=%b, required 1 within 50 cycles", in_ready);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_accept(p, s);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_sof    = 1'b1;
    in_pixel  = 9'h1AB;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    vectors++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_flags: got valid=%b last=%b, required 0 0", out_valid, out_last);
    end
    vectors++;
    if (out_window !== '0) begin
      miscompares++;
      $display("FAIL reset_out_window: got %h, required 0", out_window);
    end
`ifdef PWB_SOF_ERR_EN
    vectors++;
    if (sof_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_sof_err: got %b, required 0", sof_err);
    end
`endif
    $display("reset: in_ready=%b out_valid=%b out_window=%h", in_ready, out_valid, out_window);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_frame();
    do_reset();
    for (int n = 0; n < NPIX; n++) begin
      push(PW'(n), n == 0);
      if (n == 9) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL frame_early_valid: got %b after pixel 9, required 0", out_valid);
        end
      end
      if (n == 10) begin
        vectors++;
        if (out_valid !== 1'b1 || out_window !== mkwin(0) || out_last !== 1'b0) begin
          miscompares++;
          $display("FAIL frame_first_win: got v=%b %h l=%b, required v=1 %h l=0",
                   out_valid, out_window, out_last, mkwin(0));
        end
      end
      if (n == 15) begin
        vectors++;
        if (out_window !== mkwin(5) || out_last !== 1'b1) begin
          miscompares++;
          $display("FAIL frame_last_win: got %h l=%b, required %h l=1", out_window, out_last, mkwin(5));
        end
      end
    end
    drain();
`ifdef PWB_SOF_ERR_EN
    vectors++;
    if (sof_err !== 1'b0) begin
      miscompares++;
      $display("FAIL frame_sof_err: got %b, required 0", sof_err);
    end
`endif
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL frame_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL frame_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("frame win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    fork
      begin
        for (int n = 0; n < NPIX; n++) push(PW'(n), n == 0);
      end
      begin
        int t = 0;
        logic [9*PW-1:0] held;
        while (!out_valid && t < 100) begin
          @(posedge clk);
          #1;
          t++;
        end
        vectors++;
        if (!out_valid) begin
          miscompares++;
          $display("FAIL stall_wait_valid: out_valid=%b, required 1 within 100 cycles", out_valid);
        end
        out_ready = 1'b0;
        held = out_window;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          vectors++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_window !== held) begin
            miscompares++;
            $display("FAIL stall_hold[%0d]: got in_ready=%b v=%b %h, required 0 1 %h", c, in_ready, out_valid, out_window, held);
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL stall_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL stall_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("stall win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lasts = 0;
    do_reset();
    for (int n = 0; n < NPIX; n++) push(PW'(n), n == 0);
    for (int n = 0; n < NPIX; n++) push(PW'(100 + n), n == 0);
    drain();
    foreach (got_q[i]) if (got_q[i].last) lasts++;
    vectors++;
    if (lasts != 2) begin
      miscompares++;
      $display("FAIL b2b_last_count: got %0d, required 2", lasts);
    end
    vectors++;
    if (got_q.size() < 5 || got_q[got_q.size() >= 5 ? 4 : 0].w !== mkwin(100)) begin
      miscompares++;
      $display("FAIL b2b_frame2_first: got %0d windows, required window 4 = %h", got_q.size(), mkwin(100));
    end
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL b2b_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("b2b win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int n = 0; n < 8; n++) push(PW'(n), n == 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: got v=%b in_ready=%b, required 0 0", out_valid, in_ready);
    end
    rst = 1'b0;
    model_reset();
    // No in_sof here: the counters alone must restart at (0,0) after reset.
    for (int n = 0; n < NPIX; n++) begin
      push(PW'(n), 1'b0);
      if (n == 9) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL midrst_early_valid: got %b after pixel 9, required 0", out_valid);
        end
      end
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL midrst_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL midrst_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("midrst win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_sof_resync();
    do_reset();
    for (int n = 0; n < 5; n++) push(PW'($urandom_range(0, 511)), n == 0);
`ifdef PWB_SOF_ERR_EN
    vectors++;
    if (sof_err !== 1'b0) begin
      miscompares++;
      $display("FAIL sof_err_before: got %b, required 0", sof_err);
    end
`endif
    push(PW'($urandom_range(0, 511)), 1'b1);
`ifdef PWB_SOF_ERR_EN
    vectors++;
    if (sof_err !== 1'b1) begin
      miscompares++;
      $display("FAIL sof_err_after: got %b, required 1", sof_err);
    end
`endif
    for (int n = 1; n < NPIX; n++) begin
      push(PW'($urandom_range(0, 511)), 1'b0);
      if (n == 9 || n == 10) begin
        vectors++;
        if (out_valid !== (n == 10)) begin
          miscompares++;
          $display("FAIL sof_first_win: got out_valid=%b after %0d further pixels, required %b", out_valid, n, n == 10);
        end
      end
    end
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL sof_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sof_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("sof win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_all_ones();
    do_reset();
    for (int n = 0; n < NPIX; n++) push(9'h1FF, n == 0);
    drain();
    vectors++;
    if (got_q.size() != 4) begin
      miscompares++;
      $display("FAIL ones_count: got %0d windows, required 4", got_q.size());
    end
    foreach (got_q[i]) begin
      vectors++;
      if (got_q[i].w !== {(9*PW){1'b1}}) begin
        miscompares++;
        $display("FAIL ones_win[%0d]: got %h, required all ones", i, got_q[i].w);
      end else begin
        $display("ones win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) begin
          for (int n = 0; n < NPIX; n++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clk);
              #1;
            end
            push(PW'($urandom_range(0, 511)), (f == 0) && (n == 0));
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    vectors++;
    if (got_q.size() != exp_q.size()) begin
      miscompares++;
      $display("FAIL rand_count: got %0d windows, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL rand_win[%0d]: got %h l=%b, required %h l=%b", i, got_q[i].w, got_q[i].last, exp_q[i].w, exp_q[i].last);
      end else begin
        $display("rand win[%0d] = %h last=%b", i, got_q[i].w, got_q[i].last);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b1;
    done      = 1'b0;
    pos       = 0;
    test_reset();
    test_frame();
    test_stall();
    test_back_to_back();
    test_reset_midframe();
    test_sof_resync();
    test_all_ones();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
